// File: rtl/pwm_decoder.sv
// pwm_decoder
// Measures an incoming PWM waveform and reports its period, its high time and
// an 8-bit-scale duty cycle (high_time / period scaled to 2^DUTY_W - 1).
// Measurement is continuous: each completed period is handed to a sequential
// restoring divider while the next period is already being counted.
//
// Optional build macro: PWM_DECODER_AVG_EN
//   When defined, duty reports the truncated mean of the last four divider
//   results.  When undefined, duty is the latest result alone.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   pwm_in     asynchronous PWM input
//   duty       last duty result (DUTY_W bits)
//   period     last measured period in clk cycles (CNT_W bits)
//   high_time  last measured high time in clk cycles (CNT_W bits)
//   valid      one-cycle strobe when duty/period/high_time update
//   busy       divider running
//   stuck_hi   input held high for TIMEOUT cycles
//   stuck_lo   input held low for TIMEOUT cycles
//   overrun    sticky flag: a period was dropped because the divider was busy
module pwm_decoder #(
   parameter int CNT_W   = 16,
   parameter int DUTY_W  = 8,
   parameter int TIMEOUT = 4096
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pwm_in,
   output logic [DUTY_W-1:0] duty,
   output logic [CNT_W-1:0]  period,
   output logic [CNT_W-1:0]  high_time,
   output logic              valid,
   output logic              busy,
   output logic              stuck_hi,
   output logic              stuck_lo,
   output logic              overrun
);

   localparam int ITER_W = $clog2(DUTY_W + 1);
   localparam logic [CNT_W-1:0]  TIMEOUT_CNT = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0]  ONE_CNT     = CNT_W'(1);
   localparam logic [ITER_W-1:0] LAST_ITER   = ITER_W'(DUTY_W);

   typedef enum logic [1:0] {
      WAIT_RISE,
      HIGH,
      LOW,
      STUCK
   } state_t;

   // Synchronizer and edge-detect flops
   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;
   logic sync3_q, sync3_d;

   // Measurement FSM and counters
   state_t           state_q, state_d;
   logic [CNT_W-1:0] pcnt_q, pcnt_d;
   logic [CNT_W-1:0] hcnt_q, hcnt_d;
   logic [CNT_W-1:0] idle_q, idle_d;

   // Divider
   logic              div_busy_q, div_busy_d;
   logic [ITER_W-1:0] div_iter_q, div_iter_d;
   logic [CNT_W:0]    div_rem_q, div_rem_d;
   logic [CNT_W-1:0]  div_den_q, div_den_d;
   logic [CNT_W-1:0]  div_h_q, div_h_d;
   logic [DUTY_W:0]   div_quo_q, div_quo_d;

   // Output registers
   logic [DUTY_W-1:0] duty_q, duty_d;
   logic [CNT_W-1:0]  period_q, period_d;
   logic [CNT_W-1:0]  high_time_q, high_time_d;
   logic              valid_q, valid_d;
   logic              stuck_hi_q, stuck_hi_d;
   logic              stuck_lo_q, stuck_lo_d;
   logic              overrun_q, overrun_d;

`ifdef PWM_DECODER_AVG_EN
   logic [DUTY_W-1:0] hist_q [4];
   logic [DUTY_W-1:0] hist_d [4];
   logic [DUTY_W+1:0] avg_sum;
`endif

   logic              rise;
   logic              fall;
   logic              capture;
   logic              drop;
   logic              stuck_enter;
   logic [CNT_W:0]    div_trial;
   logic              div_ge;
   logic [CNT_W:0]    div_rem_next;
   logic [DUTY_W:0]   div_quo_next;
   logic              div_last;
   logic [DUTY_W-1:0] div_result;
   logic [DUTY_W-1:0] stuck_value;

   // Two flops bring pwm_in into the clock domain; the third holds the
   // previous synchronized level so edges can be seen.
   always_comb begin
      sync1_d = pwm_in;
      sync2_d = sync1_q;
      sync3_d = sync2_q;
      rise    = sync2_q & ~sync3_q;
      fall    = ~sync2_q & sync3_q;
   end

   // Measurement FSM.  pcnt counts the whole period and hcnt the high part;
   // every rise while measuring closes one period and opens the next.  A rise
   // takes precedence over a timeout in the same cycle.
   always_comb begin
      state_d     = state_q;
      pcnt_d      = pcnt_q;
      hcnt_d      = hcnt_q;
      idle_d      = '0;
      capture     = 1'b0;
      drop        = 1'b0;
      stuck_enter = 1'b0;
      case (state_q)
         WAIT_RISE: begin
            pcnt_d = '0;
            hcnt_d = '0;
            if (rise) begin
               state_d = HIGH;
               pcnt_d  = ONE_CNT;
               hcnt_d  = ONE_CNT;
            end else if (idle_q == TIMEOUT_CNT) begin
               state_d     = STUCK;
               stuck_enter = 1'b1;
            end else begin
               idle_d = idle_q + ONE_CNT;
            end
         end
         HIGH, LOW: begin
            if (rise) begin
               capture = ~div_busy_q;
               drop    = div_busy_q;
               state_d = HIGH;
               pcnt_d  = ONE_CNT;
               hcnt_d  = ONE_CNT;
            end else if (pcnt_q == TIMEOUT_CNT) begin
               state_d     = STUCK;
               stuck_enter = 1'b1;
               pcnt_d      = '0;
               hcnt_d      = '0;
            end else begin
               pcnt_d = pcnt_q + ONE_CNT;
               if (state_q == HIGH) begin
                  if (fall) begin
                     state_d = LOW;
                  end else begin
                     hcnt_d = hcnt_q + ONE_CNT;
                  end
               end
            end
         end
         STUCK: begin
            pcnt_d = '0;
            hcnt_d = '0;
            if (rise) begin
               state_d = HIGH;
               pcnt_d  = ONE_CNT;
               hcnt_d  = ONE_CNT;
            end
         end
         default: begin
            state_d = WAIT_RISE;
         end
      endcase
   end

   // Restoring divider producing (H << DUTY_W) / P one quotient bit per cycle.
   // Since H <= P the first step compares H itself against P (quotient MSB);
   // later steps shift the remainder left, which stays below 2P and so fits
   // in CNT_W+1 bits.
   always_comb begin
      div_busy_d   = div_busy_q;
      div_iter_d   = div_iter_q;
      div_rem_d    = div_rem_q;
      div_den_d    = div_den_q;
      div_h_d      = div_h_q;
      div_quo_d    = div_quo_q;
      div_trial    = (div_iter_q == '0) ? div_rem_q : {div_rem_q[CNT_W-1:0], 1'b0};
      div_ge       = div_trial >= {1'b0, div_den_q};
      div_rem_next = div_ge ? (div_trial - {1'b0, div_den_q}) : div_trial;
      div_quo_next = {div_quo_q[DUTY_W-1:0], div_ge};
      div_last     = div_busy_q && (div_iter_q == LAST_ITER);
      div_result   = div_quo_next[DUTY_W] ? '1 : div_quo_next[DUTY_W-1:0];
      if (capture) begin
         div_busy_d = 1'b1;
         div_iter_d = '0;
         div_rem_d  = {1'b0, hcnt_q};
         div_den_d  = pcnt_q;
         div_h_d    = hcnt_q;
         div_quo_d  = '0;
      end else if (div_busy_q) begin
         div_iter_d = div_iter_q + ITER_W'(1);
         div_rem_d  = div_rem_next;
         div_quo_d  = div_quo_next;
         if (div_last) begin
            div_busy_d = 1'b0;
         end
      end
   end

   // Result registers.  A finished division publishes a normal measurement
   // and clears any stuck indication; entering STUCK publishes the rail value.
   always_comb begin
      duty_d      = duty_q;
      period_d    = period_q;
      high_time_d = high_time_q;
      valid_d     = 1'b0;
      stuck_hi_d  = stuck_hi_q;
      stuck_lo_d  = stuck_lo_q;
      overrun_d   = overrun_q | drop;
      stuck_value = sync2_q ? '1 : '0;
`ifdef PWM_DECODER_AVG_EN
      hist_d  = hist_q;
      avg_sum = {2'b00, div_result} + {2'b00, hist_q[0]} +
                {2'b00, hist_q[1]} + {2'b00, hist_q[2]};
`endif
      if (div_last) begin
         period_d    = div_den_q;
         high_time_d = div_h_q;
         valid_d     = 1'b1;
         stuck_hi_d  = 1'b0;
         stuck_lo_d  = 1'b0;
`ifdef PWM_DECODER_AVG_EN
         hist_d[0] = div_result;
         hist_d[1] = hist_q[0];
         hist_d[2] = hist_q[1];
         hist_d[3] = hist_q[2];
         duty_d    = avg_sum[DUTY_W+1:2];
`else
         duty_d = div_result;
`endif
      end else if (stuck_enter) begin
         period_d    = '0;
         high_time_d = '0;
         valid_d     = 1'b1;
         stuck_hi_d  = sync2_q;
         stuck_lo_d  = ~sync2_q;
         duty_d      = stuck_value;
`ifdef PWM_DECODER_AVG_EN
         for (int i = 0; i < 4; i++) begin
            hist_d[i] = stuck_value;
         end
`endif
      end
   end

   // All state registers; reset is synchronous and aborts any division.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         sync3_q     <= 1'b0;
         state_q     <= WAIT_RISE;
         pcnt_q      <= '0;
         hcnt_q      <= '0;
         idle_q      <= '0;
         div_busy_q  <= 1'b0;
         div_iter_q  <= '0;
         div_rem_q   <= '0;
         div_den_q   <= '0;
         div_h_q     <= '0;
         div_quo_q   <= '0;
         duty_q      <= '0;
         period_q    <= '0;
         high_time_q <= '0;
         valid_q     <= 1'b0;
         stuck_hi_q  <= 1'b0;
         stuck_lo_q  <= 1'b0;
         overrun_q   <= 1'b0;
`ifdef PWM_DECODER_AVG_EN
         for (int i = 0; i < 4; i++) begin
            hist_q[i] <= '0;
         end
`endif
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         sync3_q     <= sync3_d;
         state_q     <= state_d;
         pcnt_q      <= pcnt_d;
         hcnt_q      <= hcnt_d;
         idle_q      <= idle_d;
         div_busy_q  <= div_busy_d;
         div_iter_q  <= div_iter_d;
         div_rem_q   <= div_rem_d;
         div_den_q   <= div_den_d;
         div_h_q     <= div_h_d;
         div_quo_q   <= div_quo_d;
         duty_q      <= duty_d;
         period_q    <= period_d;
         high_time_q <= high_time_d;
         valid_q     <= valid_d;
         stuck_hi_q  <= stuck_hi_d;
         stuck_lo_q  <= stuck_lo_d;
         overrun_q   <= overrun_d;
`ifdef PWM_DECODER_AVG_EN
         for (int i = 0; i < 4; i++) begin
            hist_q[i] <= hist_d[i];
         end
`endif
      end
   end

   assign duty      = duty_q;
   assign period    = period_q;
   assign high_time = high_time_q;
   assign valid     = valid_q;
   assign busy      = div_busy_q;
   assign stuck_hi  = stuck_hi_q;
   assign stuck_lo  = stuck_lo_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_pwm_decoder.sv
// tb_pwm_decoder
// Drives pwm_decoder with directed and random PWM waveforms and compares every
// cycle against an event-time reference model: periods and high times are
// differences of edge timestamps, duty is plain integer arithmetic, and
// pending results are kept in a queue keyed by the cycle they are due.
module tb_pwm_decoder;

   localparam int CNT_W   = 16;
   localparam int DUTY_W  = 8;
   localparam int TIMEOUT = 4096;
   localparam int FULL    = (1 << DUTY_W) - 1;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              pwm_in = 1'b0;
   logic [DUTY_W-1:0] duty;
   logic [CNT_W-1:0]  period;
   logic [CNT_W-1:0]  high_time;
   logic              valid;
   logic              busy;
   logic              stuck_hi;
   logic              stuck_lo;
   logic              overrun;

   pwm_decoder #(
      .CNT_W   (CNT_W),
      .DUTY_W  (DUTY_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .pwm_in    (pwm_in),
      .duty      (duty),
      .period    (period),
      .high_time (high_time),
      .valid     (valid),
      .busy      (busy),
      .stuck_hi  (stuck_hi),
      .stuck_lo  (stuck_lo),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      int due;
      bit is_stuck;
      bit lvl;
      int p;
      int h;
   } ev_t;

   int  n_checks = 0;
   int  n_fail = 0;
   int  cyc = 0;
   int  obs_valids = 0;
   bit  model_ready = 0;

   // Reference model state: edge timestamps rather than counters
   int  m_mode;
   int  m_start;
   int  m_fall;
   int  m_cap;
   bit  m_s1, m_s2, m_s3;
   ev_t pend[$];
   int  hist [4];

   bit  e_valid, e_busy, e_over, e_shi, e_slo;
   int  e_duty, e_period, e_high;

   // Counts one comparison and reports it when observed and expected differ.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      n_checks++;
      if (observed !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Publishes a scheduled result into the expected outputs.
   task automatic applyEvent(input ev_t ev);
      int q;
      int sum;
      e_valid = 1'b1;
      if (ev.is_stuck) begin
         e_duty   = ev.lvl ? FULL : 0;
         e_period = 0;
         e_high   = 0;
         e_shi    = ev.lvl;
         e_slo    = !ev.lvl;
         for (int i = 0; i < 4; i++) hist[i] = e_duty;
      end else begin
         q = (ev.h * (FULL + 1)) / ev.p;
         if (q > FULL) q = FULL;
         for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
         hist[0] = q;
`ifdef PWM_DECODER_AVG_EN
         sum = hist[0] + hist[1] + hist[2] + hist[3];
         e_duty = sum / 4;
`else
         sum = q;
         e_duty = sum;
`endif
         e_period = ev.p;
         e_high   = ev.h;
         e_shi    = 1'b0;
         e_slo    = 1'b0;
      end
   endtask

   // Advances the model by one clock: decides what the DUT must show in the
   // next cycle given the synchronized level seen in this one.
   task automatic modelStep(input logic pin, input logic rst);
      bit  rise;
      bit  fall;
      int  t;
      int  nt;
      ev_t ev;
      t  = cyc;
      nt = cyc + 1;
      if (rst) begin
         m_mode  = 0;
         m_start = nt;
         m_fall  = 0;
         m_cap   = -100;
         m_s1 = 0; m_s2 = 0; m_s3 = 0;
         pend.delete();
         for (int i = 0; i < 4; i++) hist[i] = 0;
         e_valid = 0; e_busy = 0; e_over = 0; e_shi = 0; e_slo = 0;
         e_duty = 0; e_period = 0; e_high = 0;
         return;
      end
      rise = m_s2 && !m_s3;
      fall = !m_s2 && m_s3;
      e_valid = 1'b0;
      if (m_mode == 1) begin
         if (rise) begin
            if (t >= m_cap + DUTY_W + 2) begin
               m_cap = t;
               ev = '{due: t + DUTY_W + 2, is_stuck: 1'b0, lvl: 1'b0,
                      p: t - m_start, h: m_fall - m_start};
               pend.push_back(ev);
            end else begin
               e_over = 1'b1;
            end
            m_start = t;
         end else if (t - m_start == TIMEOUT) begin
            m_mode = 2;
            ev = '{due: nt, is_stuck: 1'b1, lvl: m_s2, p: 0, h: 0};
            pend.push_back(ev);
         end else if (fall) begin
            m_fall = t;
         end
      end else if (m_mode == 0) begin
         if (rise) begin
            m_mode  = 1;
            m_start = t;
         end else if (t - m_start == TIMEOUT) begin
            m_mode = 2;
            ev = '{due: nt, is_stuck: 1'b1, lvl: m_s2, p: 0, h: 0};
            pend.push_back(ev);
         end
      end else begin
         if (rise) begin
            m_mode  = 1;
            m_start = t;
         end
      end
      for (int i = pend.size() - 1; i >= 0; i--) begin
         if (pend[i].due == nt) begin
            applyEvent(pend[i]);
            pend.delete(i);
         end
      end
      e_busy = (nt >= m_cap + 1) && (nt <= m_cap + DUTY_W + 1);
      m_s3 = m_s2;
      m_s2 = m_s1;
      m_s1 = pin;
   endtask

   // One clock of stimulus: check the current cycle, drive, advance model.
   task automatic applyStimulus(input logic pin, input logic rst);
      @(negedge clk);
      if (model_ready) begin
         checkOutput($sformatf("flags@%0d", cyc),
                     {59'd0, valid, busy, overrun, stuck_hi, stuck_lo},
                     {59'd0, e_valid, e_busy, e_over, e_shi, e_slo});
         checkOutput($sformatf("data@%0d", cyc),
                     {24'd0, duty, period, high_time},
                     {24'd0, DUTY_W'(e_duty), CNT_W'(e_period), CNT_W'(e_high)});
         if (valid === 1'b1) obs_valids++;
      end
      pwm_in = pin;
      reset  = rst;
      modelStep(pin, rst);
      if (rst) model_ready = 1;
      cyc++;
   endtask

   task automatic runPeriod(input int hi, input int lo);
      for (int i = 0; i < hi; i++) applyStimulus(1'b1, 1'b0);
      for (int i = 0; i < lo; i++) applyStimulus(1'b0, 1'b0);
   endtask

   task automatic doReset(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1);
   endtask

   initial begin
      int hi;
      int lo;

      // Held low from reset: one stuck-low report
      doReset(3);
      checkOutput("reset_duty", {56'd0, duty}, 64'd0);
      checkOutput("reset_valid", {63'd0, valid}, 64'd0);
      obs_valids = 0;
      for (int i = 0; i < 4110; i++) applyStimulus(1'b0, 1'b0);
      checkOutput("stuck_lo_valids", 64'(obs_valids), 64'd1);
      checkOutput("stuck_lo_flag", {63'd0, stuck_lo}, 64'd1);
      checkOutput("stuck_lo_duty", {56'd0, duty}, 64'd0);
      checkOutput("stuck_lo_period", {48'd0, period}, 64'd0);

      // 64 high / 192 low
      doReset(2);
      for (int i = 0; i < 5; i++) runPeriod(64, 192);
      checkOutput("steady_period", {48'd0, period}, 64'd256);
      checkOutput("steady_high", {48'd0, high_time}, 64'd64);
      checkOutput("steady_duty", {56'd0, duty}, 64'd64);

      // Near-full duty
      for (int i = 0; i < 4; i++) runPeriod(255, 1);
      checkOutput("full_duty", {56'd0, duty}, 64'd255);
      checkOutput("full_period", {48'd0, period}, 64'd256);
      checkOutput("full_overrun", {63'd0, overrun}, 64'd0);

      // Periods shorter than the division time
      for (int i = 0; i < 20; i++) runPeriod(1, 2);
      for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0);
      checkOutput("short_overrun", {63'd0, overrun}, 64'd1);
      checkOutput("short_period", {48'd0, period}, 64'd3);
      checkOutput("short_duty", {56'd0, duty}, 64'd85);

      // Stuck high, then recovery with a 50/50 period of 100
      for (int i = 0; i < 4200; i++) applyStimulus(1'b1, 1'b0);
      checkOutput("stuck_hi_flag", {63'd0, stuck_hi}, 64'd1);
      checkOutput("stuck_hi_duty", {56'd0, duty}, 64'd255);
      for (int i = 0; i < 50; i++) applyStimulus(1'b0, 1'b0);
      for (int i = 0; i < 5; i++) runPeriod(50, 50);
      checkOutput("recover_stuck_hi", {63'd0, stuck_hi}, 64'd0);
      checkOutput("recover_duty", {56'd0, duty}, 64'd128);
      checkOutput("recover_period", {48'd0, period}, 64'd100);

      // Random waveforms
      doReset(2);
      for (int i = 0; i < 40; i++) begin
         hi = int'($urandom_range(1, 120));
         lo = int'($urandom_range(1, 120));
         runPeriod(hi, lo);
      end
      for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0);

      // Reset three cycles into a division
      doReset(2);
      runPeriod(60, 40);
      runPeriod(60, 40);
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b1, 1'b1);
      obs_valids = 0;
      applyStimulus(1'b1, 1'b0);
      checkOutput("abort_period", {48'd0, period}, 64'd0);
      checkOutput("abort_busy", {63'd0, busy}, 64'd0);
      for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0);
      checkOutput("abort_valids", 64'(obs_valids), 64'd0);

      // Duty sequence 64, 128, 192, 255
      for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0);
      doReset(2);
      runPeriod(64, 192);
      runPeriod(128, 128);
      runPeriod(192, 64);
      runPeriod(255, 1);
      runPeriod(10, 30);
      for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0);
`ifdef PWM_DECODER_AVG_EN
      checkOutput("seq_duty", {56'd0, duty}, 64'd159);
`else
      checkOutput("seq_duty", {56'd0, duty}, 64'd255);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
